// File: rtl/spi_pkg.sv
// spi_pkg: shared types and widths for the SPI slave.
//   DATA_W  - maximum word width
//   LEN_W   - width of the word-length field (length minus one)
//   state_t - control FSM encoding
package spi_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DESEL = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep flop synchronizer for one asynchronous input bit.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (RST_VAL while in reset)
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave, all four clock modes, 1..16-bit MSB-first words.
//   ss/sck/mosi      : SPI bus inputs (async, synchronized internally)
//   miso/miso_oe     : serial output and its tristate enable
//   cpol/cpha        : clock mode, xfer_len: bits-1 (captured at word start)
//   tx_data/we       : tx buffer write (ignored while busy)
//   rx_data/rx_valid : received word and its update pulse
//   busy/done        : transfer in progress / word complete pulse
//   oe/overrun       : rx read strobe / sticky lost-word flag
// Optional build macro: SPI_SLAVE_OVERRUN_EN enables overrun detection.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              we,
    input  logic              oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    // Cycles after reset before ss_s and ss_q both reflect the real pin.
    localparam int unsigned SETTLE = SYNC_STAGES + 1;
    localparam int unsigned SET_W  = $clog2(SETTLE + 1);

    logic ss_s, sck_s, mosi_s, ss_q, sck_q;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss), .q(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sck), .q(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    state_t             state, state_nxt;
    logic [SET_W-1:0]   settle_cnt;
    logic               cpol_r, cpol_nxt, cpha_r, cpha_nxt;
    logic [LEN_W-1:0]   len_r, len_nxt, bit_cnt, bit_cnt_nxt, tx_idx, tx_idx_nxt;
    logic [DATA_W-1:0]  txsr, txsr_nxt, tx_buf, tx_buf_nxt, rx_data_nxt;
    logic [DATA_W-2:0]  rx_sr, rx_sr_nxt;
    logic               miso_nxt, miso_oe_nxt, busy_nxt, done_nxt, rx_valid_nxt;
    logic               comp;

    logic settled, ss_fall, sck_chg, lead_edge, trail_edge, sample_edge, shift_edge;

    assign settled     = (settle_cnt == SET_W'(SETTLE));
    assign ss_fall     = ss_q & ~ss_s;
    assign sck_chg     = sck_s ^ sck_q;
    assign lead_edge   = sck_chg & (sck_q == cpol_r);
    assign trail_edge  = sck_chg & (sck_q != cpol_r);
    assign sample_edge = cpha_r ? trail_edge : lead_edge;
    assign shift_edge  = cpha_r ? lead_edge : trail_edge;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            ss_q       <= 1'b1;
            sck_q      <= 1'b0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            len_r      <= '0;
            bit_cnt    <= '0;
            tx_idx     <= '0;
            txsr       <= '0;
            rx_sr      <= '0;
            tx_buf     <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
        end else begin
            state      <= state_nxt;
            if (!settled) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            ss_q       <= ss_s;
            sck_q      <= sck_s;
            cpol_r     <= cpol_nxt;
            cpha_r     <= cpha_nxt;
            len_r      <= len_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tx_idx     <= tx_idx_nxt;
            txsr       <= txsr_nxt;
            rx_sr      <= rx_sr_nxt;
            tx_buf     <= tx_buf_nxt;
            miso       <= miso_nxt;
            miso_oe    <= miso_oe_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            rx_valid   <= rx_valid_nxt;
            rx_data    <= rx_data_nxt;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_nxt    = state;
        cpol_nxt     = cpol_r;
        cpha_nxt     = cpha_r;
        len_nxt      = len_r;
        bit_cnt_nxt  = bit_cnt;
        tx_idx_nxt   = tx_idx;
        txsr_nxt     = txsr;
        rx_sr_nxt    = rx_sr;
        tx_buf_nxt   = tx_buf;
        rx_data_nxt  = rx_data;
        miso_nxt     = miso;
        done_nxt     = 1'b0;
        rx_valid_nxt = 1'b0;
        comp         = 1'b0;

        case (state)
            IDLE: begin
                miso_nxt = 1'b0;
                if (we) begin
                    tx_buf_nxt = tx_data;
                end
                if (settled) begin
                    if (ss_fall) begin
                        state_nxt   = SHIFT;
                        cpol_nxt    = cpol;
                        cpha_nxt    = cpha;
                        len_nxt     = xfer_len;
                        txsr_nxt    = tx_buf;
                        bit_cnt_nxt = '0;
                        rx_sr_nxt   = '0;
                        // cpha=1 holds off the first bit until the first leading edge.
                        if (cpha) begin
                            miso_nxt   = 1'b0;
                            tx_idx_nxt = xfer_len;
                        end else begin
                            miso_nxt   = tx_buf[xfer_len];
                            tx_idx_nxt = xfer_len - LEN_W'(1);
                        end
                    end else if (!ss_s) begin
                        // Selected without a seen falling edge (e.g. out of reset): wait it out.
                        state_nxt = DESEL;
                    end
                end
            end
            SHIFT: begin
                if (ss_s) begin
                    state_nxt = IDLE;
                    miso_nxt  = 1'b0;
                end else if (sample_edge) begin
                    rx_sr_nxt   = {rx_sr[DATA_W-3:0], mosi_s};
                    bit_cnt_nxt = bit_cnt + LEN_W'(1);
                    if (bit_cnt == len_r) begin
                        state_nxt    = DESEL;
                        rx_data_nxt  = {rx_sr, mosi_s};
                        rx_valid_nxt = 1'b1;
                        done_nxt     = 1'b1;
                        comp         = 1'b1;
                    end
                end else if (shift_edge) begin
                    miso_nxt   = txsr[tx_idx];
                    tx_idx_nxt = tx_idx - LEN_W'(1);
                end
            end
            DESEL: begin
                if (ss_s) begin
                    state_nxt = IDLE;
                    miso_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                miso_nxt  = 1'b0;
            end
        endcase

        miso_oe_nxt = (state_nxt != IDLE);
        busy_nxt    = (state_nxt != IDLE);
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_full, rx_full_nxt, overrun_nxt;

    // A completion coinciding with oe keeps rx_full set and does not flag overrun.
    always_comb begin
        rx_full_nxt = rx_full;
        overrun_nxt = overrun;
        if (comp) begin
            rx_full_nxt = 1'b1;
            if (rx_full && !oe) begin
                overrun_nxt = 1'b1;
            end
        end else if (oe) begin
            rx_full_nxt = 1'b0;
        end
        if (oe) begin
            overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            rx_full <= rx_full_nxt;
            overrun <= overrun_nxt;
        end
    end
`else
    logic unused_sigs;
    assign unused_sigs = oe | comp;
    assign overrun     = 1'b0;
`endif

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on ss, sck and mosi (minimum 2).
REQ-002 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port ss, input, 1: slave select from the bus master, active-low, asynchronous to clk.
REQ-005 Port sck, input, 1: serial clock from the master, asynchronous to clk.
REQ-006 Port mosi, input, 1: serial data from the master.
REQ-007 Port miso, output, 1: serial data to the master.
REQ-008 Port miso_oe, output, 1: tristate enable for the external miso buffer.
REQ-009 Port cpol, input, 1: clock polarity; port cpha, input, 1: clock phase.
REQ-010 Port xfer_len, input, 4: word length minus one, giving 1..16 bits.
REQ-011 Port tx_data, input, 16: word the CPU writes for transmission.
REQ-012 Port we, input, 1: one-cycle strobe that writes tx_data into the tx buffer.
REQ-013 Port oe, input, 1: one-cycle strobe marking that the CPU has read rx_data.
REQ-014 Port rx_data, output, 16: last received word.
REQ-015 Port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-016 Port busy, output, 1: a transfer is in progress.
REQ-017 Port done, output, 1: one-cycle pulse when a word completes.
REQ-018 Port overrun, output, 1: sticky flag for a lost received word.

Function
REQ-019 The FSM shall have three states, with these transitions:
- IDLE -> SHIFT on a synchronized ss falling edge.
- SHIFT -> DESEL after n = xfer_len+1 sampling edges.
- SHIFT -> IDLE on ss rising edge (abort).
- DESEL -> IDLE on ss high.
REQ-020 cpol, cpha and xfer_len shall be captured at the IDLE->SHIFT transition and held constant for the whole word.
REQ-021 Edges shall be defined as follows:
- Leading edge: sck leaves the cpol level.
- Sampling edge: leading edge if cpha=0, trailing edge if cpha=1.
- Shift edge: the opposite edge.
REQ-022 Bit order shall be MSB first; the first bit sent is txsr[n-1] and received bits are right-justified into rx[n-1:0], with upper bits zero.
REQ-023 The shift register shall load from the tx buffer at IDLE->SHIFT.
REQ-024 miso output timing shall depend on cpha:
- cpha=0: miso presents bit n-1 in the entry cycle.
- cpha=1: miso presents bit n-1 on the first leading edge.
- Each later shift edge advances miso one bit.
REQ-025 miso_oe shall be 1 in SHIFT and DESEL and 0 otherwise; miso shall be 0 whenever miso_oe is 0.
REQ-026 The n-th sampling edge is detected in cycle N; in cycle N+1 the block shall update rx_data, pulse rx_valid and done for one cycle, and enter DESEL.
REQ-027 Edges arriving in DESEL shall be ignored, with miso held at the last bit.
REQ-028 An ss deassert in SHIFT before bit n shall abort the word: no rx_valid or done, rx_data unchanged, IDLE next cycle.
REQ-029 busy shall be 1 in SHIFT and DESEL.
REQ-030 we shall write the tx buffer only when busy=0; a we while busy is dropped, and the buffer persists across transfers until rewritten.
REQ-031 sck frequency shall not exceed clk/8, and ss setup before the first sck edge shall be at least 4 clk cycles.

Reset
REQ-032 While rst is high the block shall drive: state IDLE, miso=0, miso_oe=0, busy=0, done=0, rx_valid=0, rx_data=0, tx buffer=0, overrun=0, and synchronizers at 1 for ss and 0 for sck and mosi.
REQ-033 If ss is low when rst releases, the block shall go to DESEL and not start a word until ss has gone high.
REQ-034 A reset mid-word shall discard the partial word with no done pulse.

Configuration
REQ-035 With SPI_SLAVE_OVERRUN_EN defined, overrun detection shall be built:
- An internal rx_full flag sets on rx_valid and clears on oe.
- overrun sets when a word completes while rx_full=1, and that word still overwrites rx_data.
- overrun clears on oe.
- If oe and a completion occur in the same cycle, rx_full stays 1 and overrun is not set.
REQ-036 Without SPI_SLAVE_OVERRUN_EN, overrun shall be tied to 0, oe shall be ignored and rx_full shall not exist; the port list is identical in both builds.

Structure
REQ-037 The shared package spi_pkg shall hold the FSM state encoding (IDLE, SHIFT, DESEL), DATA_W=16 and LEN_W=4.
REQ-038 There shall be one sub-module, spi_sync: a SYNC_STAGES-deep flop synchronizer with a reset value parameter, instantiated for ss, sck and mosi.

Verification
REQ-039 The bench shall cover the following directed scenarios:
- Mode 0, xfer_len=7, tx=0x00A5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x003C; one rx_valid and one done; busy falls after ss high.
- Mode 3, xfer_len=15, tx=0xBEEF, master sends 0x1234 -> master receives 0xBEEF; rx_data=0x1234.
- Mode 1, ss deasserted after 5 of 8 bits -> no done; rx_data unchanged; miso_oe=0 one cycle later; the next full word succeeds.
- A we of 0x0055 while busy -> dropped; the next transfer sends the prior buffer value.
- SPI_SLAVE_OVERRUN_EN build, two words without oe -> overrun=1 and rx_data holds the second word; oe clears overrun; the non-macro build shows overrun=0.
- rst pulse mid-word with ss held low -> all outputs at reset values; the block stays in DESEL until ss is high; the next word is received correctly.
